// File: rtl/toeplitz_skew_feeder_pkg.sv
// Shared sizing for the Toeplitz router / skew feeder pair, plus a lane slicing helper.
package toeplitz_skew_feeder_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MAX_WIDTH  = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_BITS   = MAX_WIDTH * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] lane_byte_t;

  // Byte idx of a packed row; byte 0 sits in the least significant bits.
  function automatic lane_byte_t lane_byte(input logic [ROW_BITS-1:0] row, input int idx);
    return row[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/toeplitz_skew_feeder_if.sv
// Row-in / skewed-lanes-out bundle between the router, the skew feeder and the PE array.
interface toeplitz_skew_feeder_if
  import toeplitz_skew_feeder_pkg::*;
#(
  parameter int MaxWidth  = MAX_WIDTH,
  parameter int DataWidth = DATA_WIDTH,
  parameter int FifoDepth = FIFO_DEPTH
);
  localparam int PtrWidth = $clog2(FifoDepth);

  logic                          clear;
  logic                          rowValid;
  logic [MaxWidth*DataWidth-1:0] rowData;
  logic                          rowLast;
  logic                          stall;
  logic [MaxWidth*DataWidth-1:0] laneData;
  logic [MaxWidth-1:0]           laneValid;
  logic [PtrWidth:0]             fifoCount;
  logic                          fifoFull;
  logic                          overflow;
  logic                          done;

  modport master (
    output clear, rowValid, rowData, rowLast, stall,
    input  laneData, laneValid, fifoCount, fifoFull, overflow, done
  );

  modport slave (
    input  clear, rowValid, rowData, rowLast, stall,
    output laneData, laneValid, fifoCount, fifoFull, overflow, done
  );

endinterface

// File: rtl/toeplitz_skew_feeder_row_fifo.sv
// Row FIFO: power-of-two depth, wrapping pointers, separate occupancy counter.
module toeplitz_skew_feeder_row_fifo #(
  parameter int Width    = 73,
  parameter int Depth    = 4,
  parameter int PtrWidth = $clog2(Depth)
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [Width-1:0]    wdata,
  output logic [Width-1:0]    rdata,
  output logic [PtrWidth:0]   count,
  output logic                full,
  output logic                empty
);

  localparam int CntWidth = PtrWidth + 1;

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      case ({push, pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // On a full push+pop the write lands on the slot being read this cycle; rdata is the old word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CntWidth'(Depth));
  assign empty = (count == '0);

endmodule

// File: rtl/toeplitz_skew_feeder.sv
// Buffers router rows and feeds them to the PE array diagonally skewed (lane i delayed i cycles).
module toeplitz_skew_feeder
  import toeplitz_skew_feeder_pkg::*;
#(
  parameter int MaxWidth  = MAX_WIDTH,
  parameter int DataWidth = DATA_WIDTH,
  parameter int FifoDepth = FIFO_DEPTH,
  parameter int PtrWidth  = $clog2(FifoDepth)
) (
  input  logic                 clk,
  input  logic                 nRst,
  toeplitz_skew_feeder_if.slave bus
);

  localparam int RowBits = MaxWidth * DataWidth;

  logic [RowBits:0]    fifo_rdata;
  logic [PtrWidth:0]   fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                drop;
  logic [RowBits-1:0]  pop_row;
  logic                pop_last;
  logic                overflow_q;
  logic [MaxWidth-1:0] last_q;

  assign pop      = !fifo_empty && !bus.stall;
  assign push     = bus.rowValid && (!fifo_full || pop);
  assign drop     = bus.rowValid && fifo_full && !pop;
  assign pop_row  = fifo_rdata[RowBits-1:0];
  assign pop_last = fifo_rdata[RowBits];

  toeplitz_skew_feeder_row_fifo #(
    .Width    (RowBits + 1),
    .Depth    (FifoDepth),
    .PtrWidth (PtrWidth)
  ) u_row_fifo (
    .clk   (clk),
    .nRst  (nRst),
    .clear (bus.clear),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.rowLast, bus.rowData}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  // Last-row tag rides alongside the longest lane; the tail bit is the done pulse and
  // is cleared during a stall so a held output does not pulse twice.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      last_q <= '0;
    end else if (bus.clear) begin
      last_q <= '0;
    end else if (bus.stall) begin
      last_q[MaxWidth-1] <= 1'b0;
    end else begin
      last_q <= {last_q[MaxWidth-2:0], pop & pop_last};
    end
  end

  for (genvar i = 0; i < MaxWidth; i++) begin : g_lane
    logic [DataWidth-1:0] data_q  [i+1];
    logic                 valid_q [i+1];

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        for (int k = 0; k <= i; k++) begin
          data_q[k]  <= '0;
          valid_q[k] <= 1'b0;
        end
      end else if (bus.clear) begin
        for (int k = 0; k <= i; k++) begin
          data_q[k]  <= '0;
          valid_q[k] <= 1'b0;
        end
      end else if (!bus.stall) begin
        data_q[0]  <= pop ? lane_byte(pop_row, i) : '0;
        valid_q[0] <= pop;
        for (int k = 1; k <= i; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end

    assign bus.laneData[i*DataWidth +: DataWidth] = data_q[i];
    assign bus.laneValid[i]                       = valid_q[i];
  end

  assign bus.fifoCount = fifo_count;
  assign bus.fifoFull  = fifo_full;
  assign bus.overflow  = overflow_q;
  assign bus.done      = last_q[MaxWidth-1];

endmodule

// File: doc/toeplitz_skew_feeder.md
Name: toeplitz_skew_feeder

Overview:
- Sits directly downstream of the Toeplitz router. Captures each packed MaxWidth-byte patch row when the router pulses its row-valid output.
- Buffers rows in a small FIFO, because the router has no backpressure.
- Issues rows to the PE array diagonally skewed: lane i is delayed i cycles relative to lane 0, which is what a systolic array expects.
- Tracks the router's final row and pulses a done flag when that row has fully drained from the skew pipeline.

Parameters:
- MaxWidth, 9: bytes per row; also the number of lanes (matches the router).
- DataWidth, 8: bits per byte lane.
- FifoDepth, 4: row FIFO entries; must be a power of 2, at least 2.
- PtrWidth, $clog2(FifoDepth): FIFO pointer width.

Ports:
- clk, in, 1: clock.
- nRst, in, 1: reset, asynchronous, active-low.
- clear, in, 1: synchronous flush of the FIFO, skew pipeline and sticky flags.
- rowValid, in, 1: one-cycle pulse; rowData is valid in that cycle (connects to router routingOutput).
- rowData, in, MaxWidth*DataWidth: packed row; byte i is at [(i+1)*DataWidth-1 -: DataWidth].
- rowLast, in, 1: qualifies rowValid; marks this row as the final row of the layer.
- stall, in, 1: PE array hold; freezes the skew pipeline and blocks FIFO pops.
- laneData, out, MaxWidth*DataWidth: skewed lane bytes; byte i is on lane i.
- laneValid, out, MaxWidth: per-lane valid.
- fifoCount, out, PtrWidth+1: current FIFO occupancy.
- fifoFull, out, 1: fifoCount == FifoDepth.
- overflow, out, 1: sticky; set when a row is dropped.
- done, out, 1: one-cycle pulse when lane MaxWidth-1 of the last row is emitted.

Behaviour:
- Reset (nRst=0, asynchronous):
  - All outputs go to 0: laneData, laneValid, fifoCount, fifoFull, overflow, done.
  - FIFO pointers, skew registers and the pending-last tag are cleared.
  - Reset mid-stream discards all buffered rows. No done pulse is issued for discarded rows.
- clear (synchronous) has the same effect as reset on the next edge and has priority over all other inputs.
- Pop:
  - Occurs when the FIFO is not empty and stall=0.
  - The popped row enters skew stage 0.
- Push:
  - Occurs when rowValid=1 and either fifoCount < FifoDepth, or a pop happens in the same cycle.
  - A simultaneous push and pop on a full FIFO is legal; the count stays at FifoDepth.
- Drop: rowValid=1 while full with no pop. The row is discarded, overflow is set, and the count is unchanged.
- FIFO empty with stall=0: a bubble (valid=0) enters skew stage 0.
- Skew pipeline:
  - Lane i is a shift chain of depth i+1 carrying byte i of each popped row plus a valid bit. Lane 0 therefore has 1 register stage.
  - Outputs are registered: laneData lane i and laneValid[i] are the tail of chain i.
- stall=1: every skew register and every output holds its value. The FIFO can still accept pushes.
- Latency, with the FIFO empty and no stall:
  - rowValid in cycle 0 → push at edge 1 → pop at edge 2 → laneValid[0]=1 in cycle 2.
  - laneValid[i]=1 in cycle 2+i.
  - Throughput is 1 row per cycle.
- Last-row tracking:
  - The FIFO stores a rowLast bit with each entry.
  - A last bit is carried along lane MaxWidth-1 only.
  - done pulses for 1 cycle when that bit reaches the output with stall=0, then the tag clears.
  - done is not re-pulsed while stalled.
- Pointer arithmetic:
  - Pointers wrap modulo FifoDepth.
  - fifoCount is a separate counter: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Dropped rows never set done, even when rowLast=1. overflow is visible to the controller.
- rowLast without rowValid is ignored.

Decomposition:
- Shared package holds:
  - DataWidth and MaxWidth defaults, shared with the router.
  - Lane slicing helper: function returning byte i of a packed row.
- One sub-module: row_fifo.
  - Parameterised width MaxWidth*DataWidth+1 (row plus last bit) and depth FifoDepth.
  - Ports: push, pop, count, full, empty, rdata; asynchronous active-low reset.
- Skew chains are generated in the top module with a generate loop.

Test Plan:
1. Reset: drive nRst=0 mid-stream with 3 rows buffered → all outputs 0 immediately. After release, with no new rows, laneValid stays 0 and done never pulses.
2. Single row 0x09..0x01 (byte0=0x01), rowLast=1, in cycle 0 → laneValid[i]=1 with byte value i+1 in cycle 2+i only; done=1 in cycle 10 only.
3. Burst: 6 back-to-back rows with FifoDepth=4 and stall=0 → no drop; fifoCount never exceeds 1; lane 0 outputs rows 1..6 in cycles 2..7.
4. Overflow: stall=1 and push 5 rows → fifoFull after 4 rows; row 5 dropped; overflow=1 and fifoCount=4. Release stall → rows 1–4 drain in order; overflow stays 1 until clear.
5. Stall mid-skew: row A at cycle 0, stall=1 in cycles 4–6 → laneData and laneValid frozen in cycles 4–6. Remaining lanes resume with a 3-cycle offset; lane 8 emits in cycle 13.
6. Full with simultaneous push and pop: FIFO holds 4 rows; stall falls in the same cycle rowValid pulses → row accepted; fifoCount stays 4; overflow stays 0.
